aw_thread_scheduler: RTL
========================

# aw_thread_scheduler

Cooperative thread scheduler for the Another World VM. It holds the 64 per-thread program counters and the pending setVec and updateChannel requests. Once per frame it applies the pending requests, then hands each runnable thread to the bytecode CPU in index order and waits for the thread to yield before moving on. It sits directly upstream of the CPU: the CPU receives `run_pc` and returns `yield_pc` when it hits pauseThread or killThread.

## Interface
Parameters:
- `NTHREADS`, default 64. Thread count; index width is 6.
- `PCW`, default 16. Program-counter width.

Ports:
- `clk`  in  1  Single clock, rising edge.
- `reset`  in  1  Synchronous, active-low reset.
- `frame_start`  in  1  Single-cycle pulse that starts a scheduling pass.
- `setvec_valid`  in  1  setVec request strobe.
- `setvec_thread`  in  6  Target thread of the setVec request.
- `setvec_pc`  in  16  Requested PC for the target thread.
- `chan_valid`  in  1  updateChannel request strobe.
- `chan_first`  in  6  First thread of the range, inclusive.
- `chan_last`  in  6  Last thread of the range, inclusive.
- `chan_op`  in  2  0 = resume, 1 = pause, 2 = delete, 3 = no-op.
- `run_valid`  out  1  A thread is offered to the CPU.
- `run_ready`  in  1  CPU accepts the offered thread.
- `run_thread`  out  6  Index of the offered thread.
- `run_pc`  out  16  PC of the offered thread.
- `yield_valid`  in  1  Running thread has stopped.
- `yield_pc`  in  16  PC at which the thread resumes next frame.
- `yield_kill`  in  1  Thread executed killThread.
- `busy`  out  1  High in every state except IDLE.
- `pass_done`  out  1  One-cycle pulse at the end of a pass.

## Operation
Storage per thread:
- `pc[i]`
- `req_pc[i]`
- `paused[i]`
- `req_paused[i]`

Special PC values:
- `16'hFFFF` means inactive (in `pc`) or no request (in `req_pc`).
- `16'hFFFE` in `req_pc` means kill request.

Reset values:
- `pc[0]` = 0x0000; `pc[1..63]` = 0xFFFF.
- All `req_pc` = 0xFFFF.
- All `paused` and `req_paused` = 0.
- State = IDLE.
- Outputs: `run_valid` = 0, `busy` = 0, `pass_done` = 0, `run_thread` = 0, `run_pc` = 0.

Request capture is accepted in every state and writes only the request arrays:
- setVec: `req_pc[setvec_thread]` <= `setvec_pc`.
- updateChannel, applied to every i with `chan_first` ≤ i ≤ `chan_last`, all in one cycle:
  - op 0: `req_paused[i]` <= 0.
  - op 1: `req_paused[i]` <= 1.
  - op 2: `req_pc[i]` <= 0xFFFE.
  - op 3: no effect.
- `chan_first` > `chan_last`: request ignored entirely.
- setvec and chan in the same cycle targeting the same thread's `req_pc`: setvec wins.

State machine:
- IDLE
  - `frame_start` → APPLY, index = 0.
- APPLY: one thread per cycle, index 0..63.
  - If `req_pc` = 0xFFFE, then `pc` <= 0xFFFF.
  - Else if `req_pc` ≠ 0xFFFF, then `pc` <= `req_pc`.
  - `req_pc` <= 0xFFFF.
  - `paused` <= `req_paused`.
  - After index 63 → SCAN, index = 0.
  - A new request for index i arriving in the same cycle as APPLY of i is not consumed: it is written to `req_pc` and applies next frame. `pc[i]` takes the old request.
- SCAN: one thread per cycle.
  - Thread is runnable if `pc` ≠ 0xFFFF and `paused` = 0.
  - Runnable → DISPATCH, driving `run_thread` = index and `run_pc` = `pc[index]`.
  - Otherwise advance the index. After index 63 → DONE.
- DISPATCH
  - `run_valid` = 1; `run_thread` and `run_pc` are held stable until `run_ready`.
  - `run_ready` → RUN, `run_valid` <= 0.
- RUN: wait for `yield_valid`.
  - `pc[index]` <= `yield_kill` ? 0xFFFF : `yield_pc`.
  - Then → SCAN at index+1, or → DONE if index = 63.
- DONE
  - `pass_done` = 1 for one cycle → IDLE.

Ignored inputs:
- `yield_valid` outside RUN.
- `frame_start` outside IDLE.

## Timing
- `frame_start` sampled high at cycle T (IDLE):
  - APPLY occupies T+1..T+64.
  - SCAN of thread 0 at T+65.
  - If thread 0 is runnable, `run_valid` is first high at T+66.
- Each non-runnable thread costs 1 SCAN cycle. With no runnable threads, `pass_done` is high at T+129 and IDLE resumes at T+130.
- Yield at cycle Y → SCAN of the next index at Y+1.
- `run_valid` and `run_ready` both high at cycle D → `run_valid` low at D+1. `yield_valid` is legal from D+1 onward.
- `busy` is registered and high from T+1 through the DONE cycle.
- Reset low at any cycle, including mid-pass: all storage and outputs take their reset values at the next edge. An in-flight thread is abandoned without a writeback.

## Test plan
- After reset, pulse `frame_start`, hold `run_ready` = 1 → `run_valid` at T+66 with thread 0, pc 0x0000. Yield pc 0x0123 → `pass_done` is the next SCAN boundary after 63 skips. Next frame dispatches thread 0 with pc 0x0123.
- In IDLE, setvec thread 5 pc 0x0040, then `frame_start` → dispatch order is thread 0, then thread 5 at 0x0040. No other threads are dispatched.
- chan op 1 on range 1..10 with thread 5 active → next frame thread 5 is skipped and its pc is preserved. chan op 0 on range 5..5 → the following frame dispatches thread 5 at its old pc.
- chan op 2 on range 0..0 → next frame has no dispatch and `pass_done` at T+129. chan range 10..3 → no state change.
- Thread 0 yields with `yield_kill` = 1 → the next frame has no dispatch. `yield_valid` pulsed while in IDLE → no effect.
- setvec thread 7 pc 0x0200 in the exact cycle APPLY processes index 7 → thread 7 is not run this frame and runs at 0x0200 on the frame after. `frame_start` while busy is ignored. Reset asserted during DISPATCH → `run_valid` = 0 and reset values restored.

Source files
------------

// File: rtl/aw_thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : aw_thread_scheduler
// Description : Cooperative 64-thread scheduler for the Another World VM.
//               Holds the per-thread PCs and pending setVec/updateChannel
//               requests. Each frame it applies pending requests, then
//               offers each runnable thread to the bytecode CPU in index
//               order and waits for it to yield.
// Revision    : 1.0 - initial release
// ============================================================================
module aw_thread_scheduler #(
    parameter int NTHREADS = 64,
    parameter int PCW      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          setvec_valid,
    input  logic [$clog2(NTHREADS)-1:0]   setvec_thread,
    input  logic [PCW-1:0]                setvec_pc,
    input  logic                          chan_valid,
    input  logic [$clog2(NTHREADS)-1:0]   chan_first,
    input  logic [$clog2(NTHREADS)-1:0]   chan_last,
    input  logic [1:0]                    chan_op,
    output logic                          run_valid,
    input  logic                          run_ready,
    output logic [$clog2(NTHREADS)-1:0]   run_thread,
    output logic [PCW-1:0]                run_pc,
    input  logic                          yield_valid,
    input  logic [PCW-1:0]                yield_pc,
    input  logic                          yield_kill,
    output logic                          busy,
    output logic                          pass_done
);

    localparam int IDXW = $clog2(NTHREADS);

    // Reserved PC encodings: all-ones marks an inactive thread in pc and
    // "no request" in req_pc; all-ones-minus-one in req_pc is a kill request.
    localparam logic [PCW-1:0]  c_pc_none = {PCW{1'b1}};
    localparam logic [PCW-1:0]  c_pc_kill = {{(PCW-1){1'b1}}, 1'b0};
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NTHREADS - 1);

    localparam logic [1:0] c_op_resume = 2'd0;
    localparam logic [1:0] c_op_pause  = 2'd1;
    localparam logic [1:0] c_op_delete = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_APPLY    = 3'd1,
        S_SCAN     = 3'd2,
        S_DISPATCH = 3'd3,
        S_RUN      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;

    logic [PCW-1:0]      pc_q         [NTHREADS];
    logic [PCW-1:0]      pc_d         [NTHREADS];
    logic [PCW-1:0]      req_pc_q     [NTHREADS];
    logic [PCW-1:0]      req_pc_d     [NTHREADS];
    logic                paused_q     [NTHREADS];
    logic                paused_d     [NTHREADS];
    logic                req_paused_q [NTHREADS];
    logic                req_paused_d [NTHREADS];

    logic                run_valid_q, run_valid_d;
    logic                busy_q, busy_d;
    logic                pass_done_q, pass_done_d;
    logic [IDXW-1:0]     run_thread_q, run_thread_d;
    logic [PCW-1:0]      run_pc_q, run_pc_d;

    logic                w_chan_ok;
    logic                w_runnable;
    logic                w_yield;

    // An inverted range disables the whole channel request.
    assign w_chan_ok  = chan_valid && (chan_first <= chan_last);
    assign w_runnable = (pc_q[idx_q] != c_pc_none) && !paused_q[idx_q];
    // Yields are only meaningful while a thread is actually running.
    assign w_yield    = (state_q == S_RUN) && yield_valid;

    // ------------------------------------------------------------------
    // Per-thread storage update: request capture, APPLY commit, writeback
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NTHREADS; i++) begin
            logic in_range;
            logic at_idx;

            pc_d[i]         = pc_q[i];
            req_pc_d[i]     = req_pc_q[i];
            paused_d[i]     = paused_q[i];
            req_paused_d[i] = req_paused_q[i];

            in_range = w_chan_ok && (chan_first <= IDXW'(i)) && (IDXW'(i) <= chan_last);
            at_idx   = (idx_q == IDXW'(i));

            // Commit the pending request for the thread under APPLY.
            if (state_q == S_APPLY && at_idx) begin
                if (req_pc_q[i] == c_pc_kill) begin
                    pc_d[i] = c_pc_none;
                end else if (req_pc_q[i] != c_pc_none) begin
                    pc_d[i] = req_pc_q[i];
                end
                req_pc_d[i] = c_pc_none;
                paused_d[i] = req_paused_q[i];
            end

            // Writeback of the running thread's resume point.
            if (w_yield && at_idx) begin
                pc_d[i] = yield_kill ? c_pc_none : yield_pc;
            end

            // New requests override the APPLY clear so they survive to the
            // next frame; setVec has priority over a channel delete.
            if (in_range) begin
                case (chan_op)
                    c_op_resume: req_paused_d[i] = 1'b0;
                    c_op_pause:  req_paused_d[i] = 1'b1;
                    c_op_delete: req_pc_d[i]     = c_pc_kill;
                    default:     ;
                endcase
            end
            if (setvec_valid && (setvec_thread == IDXW'(i))) begin
                req_pc_d[i] = setvec_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM: next state, index and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        run_thread_d = run_thread_q;
        run_pc_d     = run_pc_q;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_APPLY;
                    idx_d   = '0;
                end
            end
            S_APPLY: begin
                if (idx_q == c_last_idx) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_SCAN: begin
                if (w_runnable) begin
                    state_d      = S_DISPATCH;
                    run_thread_d = idx_q;
                    run_pc_d     = pc_q[idx_q];
                end else if (idx_q == c_last_idx) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DISPATCH: begin
                if (run_ready) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (yield_valid) begin
                    if (idx_q == c_last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SCAN;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered decodes of the next state.
        run_valid_d = (state_d == S_DISPATCH);
        busy_d      = (state_d != S_IDLE);
        pass_done_d = (state_d == S_DONE);
    end

    // ------------------------------------------------------------------
    // State and storage registers with synchronous active-low reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            run_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            pass_done_q  <= 1'b0;
            run_thread_q <= '0;
            run_pc_q     <= '0;
            for (int i = 0; i < NTHREADS; i++) begin
                pc_q[i]         <= (i == 0) ? '0 : c_pc_none;
                req_pc_q[i]     <= c_pc_none;
                paused_q[i]     <= 1'b0;
                req_paused_q[i] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            run_valid_q  <= run_valid_d;
            busy_q       <= busy_d;
            pass_done_q  <= pass_done_d;
            run_thread_q <= run_thread_d;
            run_pc_q     <= run_pc_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            paused_q     <= paused_d;
            req_paused_q <= req_paused_d;
        end
    end

    assign run_valid  = run_valid_q;
    assign busy       = busy_q;
    assign pass_done  = pass_done_q;
    assign run_thread = run_thread_q;
    assign run_pc     = run_pc_q;

endmodule
`default_nettype wire
